demux_class_buf: RTL and testbench

- Receive-side counterpart of the 4-class merge stage in the transaction layer.
- Accepts a single stream of 12-bit words. Bits [11:10] carry the class ID (0..3); bits [9:0] carry the payload.
- Steers each word into one of four per-class FIFOs.
- Each FIFO is drained independently by its consumer.
- An all-zero word is the idle code and is never stored.

---
 rtl/demux_class_buf_pkg.sv | 24 ++
 rtl/demux_class_buf_class_fifo.sv | 71 +++++++
 rtl/demux_class_buf.sv | 96 +++++++++
 tb/tb_demux_class_buf.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/demux_class_buf_pkg.sv
// Shared definitions for the 4-class receive demultiplexer: word layout,
// class encodings and the idle code.
package demux_class_buf_pkg;

  localparam int DATA_W      = 12;
  localparam int CLASS_W     = 2;
  localparam int CLASS_MSB   = 11;
  localparam int CLASS_LSB   = 10;
  localparam int NUM_CLASSES = 4;

  typedef enum logic [CLASS_W-1:0] {
    CLS0 = 2'd0,
    CLS1 = 2'd1,
    CLS2 = 2'd2,
    CLS3 = 2'd3
  } class_e;

  localparam logic [DATA_W-1:0] IDLE_WORD = 12'd0;

  function automatic class_e word_class(input logic [DATA_W-1:0] word);
    return class_e'(word[CLASS_MSB:CLASS_LSB]);
  endfunction

endpackage

// File: rtl/demux_class_buf_class_fifo.sv
// Single-class first-word-fall-through FIFO. Flags come from the registered
// occupancy only; overflow/underflow are single-cycle pulses.
module class_fifo
  import demux_class_buf_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_en_s, rd_en_s, empty_s, full_s;

  always_comb begin
    empty_s  = (count_q == {CNT_W{1'b0}});
    full_s   = (count_q == CNT_W'(DEPTH));
    wr_en_s  = push_i && !full_s;
    rd_en_s  = pop_i && !empty_s;
    wr_ptr_d = wr_en_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = rd_en_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o        = empty_s ? {DATA_W{1'b0}} : mem_q[rd_ptr_q];
  assign empty_o       = empty_s;
  assign full_o        = full_s;
  assign almost_full_o = (count_q >= CNT_W'(AF_LEVEL));
  assign overflow_o    = push_i && full_s;
  assign underflow_o   = pop_i && empty_s;

endmodule

// File: rtl/demux_class_buf.sv
// Steers an incoming word stream into four per-class FWFT FIFOs by the class
// field in the top two bits; idle (all-zero) words are never stored.
module demux_class_buf
  import demux_class_buf_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_in,
  input  logic              push,
  output logic              ready,
  input  logic              pop0,
  input  logic              pop1,
  input  logic              pop2,
  input  logic              pop3,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic              empty0,
  output logic              empty1,
  output logic              empty2,
  output logic              empty3,
  output logic              full0,
  output logic              full1,
  output logic              full2,
  output logic              full3,
  output logic              almost_full0,
  output logic              almost_full1,
  output logic              almost_full2,
  output logic              almost_full3,
  output logic              err_overflow,
  output logic              err_underflow
);

  class_e                 cls_s;
  logic [NUM_CLASSES-1:0] push_s, pop_s, empty_s, full_s, af_s, ovf_s, unf_s;
  logic [DATA_W-1:0]      dout_s [NUM_CLASSES];
  logic                   err_overflow_q, err_overflow_d;
  logic                   err_underflow_q, err_underflow_d;

  // Ready looks only at registered fullness, so a same-cycle pop never opens a full class.
  always_comb begin
    cls_s          = word_class(data_in);
    push_s         = {NUM_CLASSES{1'b0}};
    push_s[cls_s]  = push && (data_in != IDLE_WORD);
    ready          = !full_s[cls_s];
    err_overflow_d  = err_overflow_q || (|ovf_s);
    err_underflow_d = err_underflow_q || (|unf_s);
  end

  assign pop_s = {pop3, pop2, pop1, pop0};

  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_fifo
    class_fifo #(
      .DEPTH   (DEPTH),
      .AF_LEVEL(AF_LEVEL)
    ) u_fifo (
      .clk          (clk),
      .reset_L      (reset_L),
      .push_i       (push_s[g]),
      .data_i       (data_in),
      .pop_i        (pop_s[g]),
      .data_o       (dout_s[g]),
      .empty_o      (empty_s[g]),
      .full_o       (full_s[g]),
      .almost_full_o(af_s[g]),
      .overflow_o   (ovf_s[g]),
      .underflow_o  (unf_s[g])
    );
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;

  assign data_out0 = dout_s[0];
  assign data_out1 = dout_s[1];
  assign data_out2 = dout_s[2];
  assign data_out3 = dout_s[3];
  assign {empty3, empty2, empty1, empty0}                         = empty_s;
  assign {full3, full2, full1, full0}                             = full_s;
  assign {almost_full3, almost_full2, almost_full1, almost_full0} = af_s;

endmodule

// File: tb/tb_demux_class_buf.sv
// Directed plus randomized bench for demux_class_buf, checked against a
// queue-based model of four independent class FIFOs.
module tb_demux_class_buf;

  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic [11:0] data_in = 12'h000;
  logic        push = 1'b0;
  logic [3:0]  pops = 4'b0000;
  logic        ready, err_overflow, err_underflow;
  logic [11:0] dout [4];
  logic [3:0]  empty_v, full_v, af_v;

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] mq [4][$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  always #5 clk = ~clk;

  demux_class_buf #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .push(push), .ready(ready),
    .pop0(pops[0]), .pop1(pops[1]), .pop2(pops[2]), .pop3(pops[3]),
    .data_out0(dout[0]), .data_out1(dout[1]), .data_out2(dout[2]), .data_out3(dout[3]),
    .empty0(empty_v[0]), .empty1(empty_v[1]), .empty2(empty_v[2]), .empty3(empty_v[3]),
    .full0(full_v[0]), .full1(full_v[1]), .full2(full_v[2]), .full3(full_v[3]),
    .almost_full0(af_v[0]), .almost_full1(af_v[1]), .almost_full2(af_v[2]),
    .almost_full3(af_v[3]),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < 4; c++) begin
      int sz;
      logic [11:0] head;
      sz   = mq[c].size();
      head = (sz > 0) ? mq[c][0] : 12'h000;
      chk($sformatf("%s_c%0d", tag, c),
          {1'b0, empty_v[c], full_v[c], af_v[c], dout[c]},
          {1'b0, sz == 0, sz == DEPTH, sz >= AF, head});
    end
    chk($sformatf("%s_err", tag), {14'd0, err_overflow, err_underflow}, {14'd0, m_ovf, m_unf});
  endtask

  // Reference behaviour of one clock edge, decided on pre-edge occupancies.
  task automatic model_edge(input logic p, input logic [11:0] d, input logic [3:0] pp);
    int sz [4];
    int cls;
    for (int c = 0; c < 4; c++) sz[c] = mq[c].size();
    for (int c = 0; c < 4; c++) begin
      if (pp[c]) begin
        if (sz[c] == 0) m_unf = 1'b1;
        else void'(mq[c].pop_front());
      end
    end
    if (p && d != 12'h000) begin
      cls = int'(d[11:10]);
      if (sz[cls] == DEPTH) m_ovf = 1'b1;
      else mq[cls].push_back(d);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 4; c++) mq[c].delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle(input string tag, input logic p, input logic [11:0] d, input logic [3:0] pp);
    int cls;
    push    = p;
    data_in = d;
    pops    = pp;
    #1;
    cls = int'(d[11:10]);
    chk($sformatf("%s_ready", tag), {15'd0, ready}, {15'd0, mq[cls].size() != DEPTH});
    @(posedge clk);
    model_edge(p, d, pp);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    reset_L = 1'b0;
    push    = 1'b0;
    pops    = 4'b0000;
    data_in = 12'h000;
    #1;
    model_clear();
    check_all(tag);
    chk($sformatf("%s_ready", tag), {15'd0, ready}, 16'd1);
    @(negedge clk);
    reset_L = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] w;
    logic [11:0] stim [4];

    do_reset("reset");

    for (int i = 0; i < 5; i++) cycle("idle", 1'b1, 12'h000, 4'b0000);

    stim[0] = 12'h005; stim[1] = 12'h40A; stim[2] = 12'h80F; stim[3] = 12'hC01;
    for (int i = 0; i < 4; i++) cycle("route", 1'b1, stim[i], 4'b0000);

    do_reset("reset_fill");
    for (int i = 1; i <= 4; i++) cycle("fill1", 1'b1, 12'h400 + 12'(i), 4'b0000);
    cycle("ovf1", 1'b1, 12'h405, 4'b0000);
    for (int i = 0; i < 5; i++) cycle("drain1", 1'b0, 12'h400, 4'b0010);

    do_reset("reset_wrap");
    cycle("wrap_pre", 1'b1, 12'h8A0, 4'b0000);
    cycle("wrap_pre", 1'b1, 12'h8A1, 4'b0000);
    for (int i = 0; i < 10; i++) cycle("wrap", 1'b1, 12'h8B0 + 12'(i), 4'b0100);

    cycle("full_pp", 1'b1, 12'h8C0, 4'b0000);
    cycle("full_pp", 1'b1, 12'h8C1, 4'b0000);
    cycle("full_pp", 1'b1, 12'h8C2, 4'b0100);

    for (int i = 0; i < 6; i++) cycle("partial", 1'b1, {2'(i), 10'h1F0 + 10'(i)}, 4'b0000);
    do_reset("reset_mid");

    for (int i = 0; i < 400; i++) begin
      if (i % 80 == 79) do_reset("reset_rand");
      w = 12'($urandom);
      if ($urandom_range(0, 7) == 0) w = 12'h000;
      cycle("rand", $urandom_range(0, 3) != 0, w,
            4'($urandom) & 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
